// File: rtl/cgol_pkg.sv
// Shared definitions for the Game of Life engine.
//   cgol_state_t    : scheduler FSM states (IDLE, SCAN, FLUSH)
//   CELL_CENTER_BIT : position of the center cell in the packed 3x3 neighborhood
//   NBHD_W          : width of the packed 3x3 neighborhood
//   wrap_dec/inc    : cyclic coordinate step on a torus of size lim
package cgol_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } cgol_state_t;

    localparam int CELL_CENTER_BIT = 5;
    localparam int NBHD_W          = 9;

    function automatic int wrap_dec(input int v, input int lim);
        return (v == 0) ? lim - 1 : v - 1;
    endfunction

    function automatic int wrap_inc(input int v, input int lim);
        return (v == lim - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cgol_cell.sv
// Single-cell Game of Life rule with a registered result.
//   clk                : clock
//   i_local_game_board : packed 3x3 neighborhood, center at CELL_CENTER_BIT
//   o_cell             : next state of the center cell, one cycle later
// The output register has no reset; consumers qualify it with their own valid.
module cgol_cell
    import cgol_pkg::*;
(
    input  logic              clk,
    input  logic [NBHD_W-1:0] i_local_game_board,
    output logic              o_cell
);

    logic [3:0] count;

    // Live-neighbor count over the eight non-center positions.
    always_comb begin
        count = '0;
        for (int i = 0; i < NBHD_W; i++) begin
            if (i != CELL_CENTER_BIT) begin
                count = count + {3'd0, i_local_game_board[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        o_cell <= (count == 4'd3) ||
                  (i_local_game_board[CELL_CENTER_BIT] && (count == 4'd2));
    end

endmodule

// File: rtl/cgol_scheduler.sv
// Generation sequencer: scans every cell of the front buffer through one
// shared cgol_cell, writes results into the back buffer, then swaps buffers.
//   clk, rst        : clock, asynchronous active-high reset
//   i_step          : start one generation (IDLE only)
//   i_load_en/addr/value : single-cell write into the front buffer (IDLE only)
//   i_clear         : zero the front buffer and generation count (IDLE only;
//                     wins over a simultaneous load)
//   o_board         : front buffer, bit y*W + x
//   o_busy          : high while SCAN or FLUSH
//   o_done          : one-cycle pulse after a generation is committed
//   o_generation    : completed generation count, wraps at 2^16
// Handshake: i_step is a level sampled only in IDLE; nothing is queued while
// busy, so a step raised during a scan is simply dropped.
module cgol_scheduler
    import cgol_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8,
    localparam int N  = W * H,
    localparam int AW = $clog2(N)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_step,
    input  logic          i_load_en,
    input  logic [AW-1:0] i_load_addr,
    input  logic          i_load_value,
    input  logic          i_clear,
    output logic [N-1:0]  o_board,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_generation
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    cgol_state_t        state;
    cgol_state_t        state_next;
    logic [N-1:0]       board_q [2];
    logic               sel;
    logic [AW-1:0]      idx;
    logic               wr_valid;
    logic [AW-1:0]      wr_addr;
    logic [N-1:0]       front;
    logic [NBHD_W-1:0]  nbhd;
    logic               cell_result;

    assign front   = board_q[sel];
    assign o_board = front;
    assign o_busy  = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_step) state_next = SCAN;
            SCAN:    if (idx == LAST_IDX) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Neighborhood gather ----------------
    function automatic logic cell_at(input logic [N-1:0] b, input int cx, input int cy);
        logic [AW-1:0] a;
        a = AW'(cy * W + cx);
        return b[a];
    endfunction

    always_comb begin
        int cx, cy, xm, xp, ym, yp;
        cx = int'(idx) % W;
        cy = int'(idx) / W;
        xm = wrap_dec(cx, W);
        xp = wrap_inc(cx, W);
        ym = wrap_dec(cy, H);
        yp = wrap_inc(cy, H);
        nbhd    = '0;
        nbhd[0] = cell_at(front, xm, ym);
        nbhd[1] = cell_at(front, cx, ym);
        nbhd[2] = cell_at(front, xp, ym);
        nbhd[3] = cell_at(front, xm, cy);
        nbhd[4] = cell_at(front, xp, cy);
        nbhd[5] = cell_at(front, cx, cy);
        nbhd[6] = cell_at(front, xm, yp);
        nbhd[7] = cell_at(front, cx, yp);
        nbhd[8] = cell_at(front, xp, yp);
    end

    cgol_cell u_cell (
        .clk                (clk),
        .i_local_game_board (nbhd),
        .o_cell             (cell_result)
    );

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q[0]   <= '0;
            board_q[1]   <= '0;
            sel          <= 1'b0;
            idx          <= '0;
            wr_valid     <= 1'b0;
            wr_addr      <= '0;
            o_done       <= 1'b0;
            o_generation <= '0;
        end else begin
            o_done   <= (state == FLUSH);
            // Index presented this cycle has its result on cell_result next cycle.
            wr_valid <= (state == SCAN);
            wr_addr  <= idx;

            case (state)
                IDLE: begin
                    if (i_clear) begin
                        board_q[sel] <= '0;
                        o_generation <= '0;
                    end else if (i_load_en) begin
                        board_q[sel][i_load_addr] <= i_load_value;
                    end
                    if (i_step) idx <= '0;
                end
                SCAN: begin
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                FLUSH: begin
                    sel          <= ~sel;
                    o_generation <= o_generation + 16'd1;
                end
                default: ;
            endcase

            // Loads only occur in IDLE and writes only after SCAN, so the
            // two targets never collide.
            if (wr_valid) board_q[~sel][wr_addr] <= cell_result;
        end
    end

endmodule

// File: tb/tb_cgol_scheduler.sv
module tb_cgol_scheduler;

    logic        clk;
    logic        rst;
    logic        i_step;
    logic        i_load_en;
    logic [5:0]  i_load_addr;
    logic        i_load_value;
    logic        i_clear;
    logic [63:0] o_board;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_generation;

    int n_tests = 0;
    int n_fail  = 0;

    cgol_scheduler #(.W(8), .H(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_step       (i_step),
        .i_load_en    (i_load_en),
        .i_load_addr  (i_load_addr),
        .i_load_value (i_load_value),
        .i_clear      (i_clear),
        .o_board      (o_board),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_generation (o_generation)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [63:0] mk(input int a, input int b, input int c,
                                       input int d = -1, input int e = -1);
        logic [63:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        if (e >= 0) r[e] = 1'b1;
        return r;
    endfunction

    task automatic do_load(input int a, input logic v);
        i_load_en    = 1'b1;
        i_load_addr  = 6'(a);
        i_load_value = v;
        tick();
        i_load_en    = 1'b0;
        i_load_value = 1'b0;
    endtask

    task automatic load_set(input logic [63:0] p);
        for (int i = 0; i < 64; i++) begin
            if (p[i]) do_load(i, 1'b1);
        end
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    // Step and wait for o_done; lat = edges from accepting edge to done cycle.
    task automatic run_gen(output int lat, output logic busy0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        busy0 = o_busy;
        lat = 0;
        while (o_done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_tests++; if (o_board !== 64'd0) begin n_fail++; $display("FAIL reset_board got %h want 0", o_board); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
        n_tests++; if (o_generation !== 16'd0) begin n_fail++; $display("FAIL reset_gen got %0d want 0", o_generation); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_blinker();
        int lat;
        logic busy0;
        logic [63:0] vert, horz;
        vert = mk(19, 27, 35);
        horz = mk(26, 27, 28);
        load_set(vert);
        n_tests++; if (o_board !== vert) begin n_fail++; $display("FAIL blinker_load got %h want %h", o_board, vert); end
        run_gen(lat, busy0);
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL blinker_busy got %b want 1", busy0); end
        n_tests++; if (lat != 65) begin n_fail++; $display("FAIL blinker_latency got %0d want 65", lat); end
        n_tests++; if (o_board !== horz) begin n_fail++; $display("FAIL blinker_gen1 got %h want %h", o_board, horz); end
        n_tests++; if (o_generation !== 16'd1) begin n_fail++; $display("FAIL blinker_count1 got %0d want 1", o_generation); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL blinker_idle got %b want 0", o_busy); end
        tick();
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL blinker_done_pulse got %b want 0", o_done); end
        run_gen(lat, busy0);
        n_tests++; if (o_board !== vert) begin n_fail++; $display("FAIL blinker_gen2 got %h want %h", o_board, vert); end
        n_tests++; if (o_generation !== 16'd2) begin n_fail++; $display("FAIL blinker_count2 got %0d want 2", o_generation); end
    endtask

    task automatic test_clear();
        // clear wins over a simultaneous load
        i_clear = 1'b1;
        i_load_en = 1'b1; i_load_addr = 6'd5; i_load_value = 1'b1;
        tick();
        i_clear = 1'b0; i_load_en = 1'b0; i_load_value = 1'b0;
        n_tests++; if (o_board !== 64'd0) begin n_fail++; $display("FAIL clear_board got %h want 0", o_board); end
        n_tests++; if (o_generation !== 16'd0) begin n_fail++; $display("FAIL clear_gen got %0d want 0", o_generation); end
    endtask

    task automatic test_corner_block();
        int lat;
        logic busy0;
        logic [63:0] blk;
        blk = mk(0, 7, 56, 63);
        do_clear();
        load_set(blk);
        for (int g = 0; g < 3; g++) run_gen(lat, busy0);
        n_tests++; if (o_board !== blk) begin n_fail++; $display("FAIL corner_board got %h want %h", o_board, blk); end
        n_tests++; if (o_generation !== 16'd3) begin n_fail++; $display("FAIL corner_gen got %0d want 3", o_generation); end
    endtask

    task automatic test_glider();
        int lat;
        logic busy0;
        logic [63:0] gl, gl4;
        gl  = mk(1, 10, 16, 17, 18);
        gl4 = mk(10, 19, 25, 26, 27); // shifted by (+1,+1)
        do_clear();
        load_set(gl);
        for (int g = 0; g < 4; g++) run_gen(lat, busy0);
        n_tests++; if (o_board !== gl4) begin n_fail++; $display("FAIL glider_gen4 got %h want %h", o_board, gl4); end
        for (int g = 0; g < 28; g++) run_gen(lat, busy0);
        n_tests++; if (o_board !== gl) begin n_fail++; $display("FAIL glider_gen32 got %h want %h", o_board, gl); end
        n_tests++; if (o_generation !== 16'd32) begin n_fail++; $display("FAIL glider_count got %0d want 32", o_generation); end
    endtask

    task automatic test_load_with_step();
        int lat;
        logic busy0;
        do_clear();
        do_load(19, 1'b1);
        do_load(27, 1'b1);
        // last load shares its edge with the step
        i_load_en = 1'b1; i_load_addr = 6'd35; i_load_value = 1'b1;
        run_gen(lat, busy0);
        n_tests++; if (o_board !== mk(26, 27, 28)) begin n_fail++; $display("FAIL load_step_board got %h want %h", o_board, mk(26, 27, 28)); end
        i_load_en = 1'b0; i_load_value = 1'b0;
        tick();
        // clear together with step: empty board is scanned
        i_clear = 1'b1;
        run_gen(lat, busy0);
        i_clear = 1'b0;
        n_tests++; if (o_board !== 64'd0) begin n_fail++; $display("FAIL clear_step_board got %h want 0", o_board); end
        n_tests++; if (o_generation !== 16'd1) begin n_fail++; $display("FAIL clear_step_gen got %0d want 1", o_generation); end
        tick();
    endtask

    task automatic test_interference();
        int dones;
        logic [63:0] board_at_done;
        logic [15:0] gen_at_done;
        do_clear();
        load_set(mk(26, 27, 28));
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        repeat (10) tick();
        i_step = 1'b1; i_clear = 1'b1;
        i_load_en = 1'b1; i_load_addr = 6'd0; i_load_value = 1'b1;
        tick();
        i_step = 1'b0; i_clear = 1'b0; i_load_en = 1'b0; i_load_value = 1'b0;
        dones = 0;
        board_at_done = '0;
        gen_at_done = '0;
        for (int c = 0; c < 200; c++) begin
            if (o_done === 1'b1) begin
                dones++;
                board_at_done = o_board;
                gen_at_done = o_generation;
            end
            tick();
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
        n_tests++; if (board_at_done !== mk(19, 27, 35)) begin n_fail++; $display("FAIL busy_ignore_board got %h want %h", board_at_done, mk(19, 27, 35)); end
        n_tests++; if (gen_at_done !== 16'd1) begin n_fail++; $display("FAIL busy_ignore_gen got %0d want 1", gen_at_done); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int dones;
        int busy_cycles;
        logic busy0;
        do_clear();
        load_set(mk(19, 27, 35));
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        #1;
        n_tests++; if (o_board !== 64'd0) begin n_fail++; $display("FAIL midrst_board got %h want 0", o_board); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", o_busy); end
        n_tests++; if (o_generation !== 16'd0) begin n_fail++; $display("FAIL midrst_gen got %0d want 0", o_generation); end
        tick();
        rst = 1'b0;
        dones = 0;
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_done === 1'b1) dones++;
            if (o_busy === 1'b1) busy_cycles++;
            tick();
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        n_tests++; if (busy_cycles != 0) begin n_fail++; $display("FAIL midrst_no_busy got %0d want 0", busy_cycles); end
        load_set(mk(19, 27, 35));
        run_gen(lat, busy0);
        n_tests++; if (lat != 65) begin n_fail++; $display("FAIL midrst_latency got %0d want 65", lat); end
        n_tests++; if (o_board !== mk(26, 27, 28)) begin n_fail++; $display("FAIL midrst_board_gen1 got %h want %h", o_board, mk(26, 27, 28)); end
        n_tests++; if (o_generation !== 16'd1) begin n_fail++; $display("FAIL midrst_gen1 got %0d want 1", o_generation); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst          = 1'b1;
        i_step       = 1'b0;
        i_load_en    = 1'b0;
        i_load_addr  = '0;
        i_load_value = 1'b0;
        i_clear      = 1'b0;
        test_reset();
        test_blinker();
        test_clear();
        test_corner_block();
        test_glider();
        test_load_with_step();
        test_interference();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
